// File: rtl/cpu_hazard_unit_if.sv
// Bundle between the ID stage and the hazard unit: the ID instruction's
// register use in one direction, and the forward/stall/bubble decisions in the other.
interface cpu_hazard_unit_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FWD_DEPTH      = 2
);
  localparam int SW = $clog2(FWD_DEPTH + 1);

  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] id_rn;
  logic [REG_ADDR_WIDTH-1:0] id_rb;
  logic                      id_use_a;
  logic                      id_use_b;
  logic                      id_reg_wren;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic                      id_is_load;
  logic                      flush;
  logic [SW-1:0]             forward_a;
  logic [SW-1:0]             forward_b;
  logic                      stall;
  logic                      bubble;
  logic [31:0]               stall_count;

  modport master (
    output id_valid, id_rn, id_rb, id_use_a, id_use_b,
           id_reg_wren, id_rd, id_is_load, flush,
    input  forward_a, forward_b, stall, bubble, stall_count
  );

  modport slave (
    input  id_valid, id_rn, id_rb, id_use_a, id_use_b,
           id_reg_wren, id_rd, id_is_load, flush,
    output forward_a, forward_b, stall, bubble, stall_count
  );
endinterface

// File: rtl/cpu_hazard_unit.sv
// Forwarding select and load-use stall detection for an in-order pipeline.
// Optional stall statistics counter enabled by macro HAZARD_STALL_COUNT_EN.
module cpu_hazard_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ZERO_REG       = 31,
  parameter int FWD_DEPTH      = 2
) (
  input  logic            clk,
  input  logic            reset,
  cpu_hazard_unit_if.slave hz
);
  localparam int SW = $clog2(FWD_DEPTH + 1);
  localparam logic [REG_ADDR_WIDTH-1:0] ZR = REG_ADDR_WIDTH'(ZERO_REG);

  // Tracker entry 1 is the instruction now in EX, entry k is k stages downstream.
  logic [FWD_DEPTH:1]        r_valid;
  logic [FWD_DEPTH:1]        r_wren;
  logic [FWD_DEPTH:1]        r_load;
  logic [REG_ADDR_WIDTH-1:0] r_rd [1:FWD_DEPTH];

  logic [FWD_DEPTH:1]        w_in_valid;
  logic [FWD_DEPTH:1]        w_in_wren;
  logic [FWD_DEPTH:1]        w_in_load;
  logic [REG_ADDR_WIDTH-1:0] w_in_rd [1:FWD_DEPTH];

  logic [FWD_DEPTH:1]        w_match_a;
  logic [FWD_DEPTH:1]        w_match_b;
  logic [SW-1:0]             w_fwd_a;
  logic [SW-1:0]             w_fwd_b;
  logic                      w_load_a;
  logic                      w_load_b;
  logic                      w_stall;
  logic                      w_unused_load;

  genvar gi;
  generate
    for (gi = 1; gi <= FWD_DEPTH; gi++) begin : g_entry
      if (gi == 1) begin : g_head
        assign w_in_valid[gi] = hz.id_valid & ~hz.flush & ~w_stall;
        assign w_in_wren[gi]  = hz.id_reg_wren;
        assign w_in_load[gi]  = hz.id_is_load;
        assign w_in_rd[gi]    = hz.id_rd;
      end else begin : g_tail
        assign w_in_valid[gi] = r_valid[gi-1];
        assign w_in_wren[gi]  = r_wren[gi-1];
        assign w_in_load[gi]  = r_load[gi-1];
        assign w_in_rd[gi]    = r_rd[gi-1];
      end

      assign w_match_a[gi] = hz.id_valid & hz.id_use_a & r_valid[gi] & r_wren[gi] &
                             (r_rd[gi] == hz.id_rn) & (r_rd[gi] != ZR);
      assign w_match_b[gi] = hz.id_valid & hz.id_use_b & r_valid[gi] & r_wren[gi] &
                             (r_rd[gi] == hz.id_rb) & (r_rd[gi] != ZR);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_wren  <= '0;
      r_load  <= '0;
      for (int k = 1; k <= FWD_DEPTH; k++) r_rd[k] <= '0;
    end else begin
      r_valid <= w_in_valid;
      r_wren  <= w_in_wren;
      r_load  <= w_in_load;
      for (int k = 1; k <= FWD_DEPTH; k++) r_rd[k] <= w_in_rd[k];
    end
  end

  // Scan oldest to youngest so the nearest producer overwrites older matches.
  always_comb begin
    w_fwd_a = '0;
    w_fwd_b = '0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (w_match_a[k]) w_fwd_a = SW'(k);
      if (w_match_b[k]) w_fwd_b = SW'(k);
    end
  end

  assign w_load_a = w_match_a[1] & r_load[1];
  assign w_load_b = w_match_b[1] & r_load[1];
  assign w_stall  = (w_load_a | w_load_b) & hz.id_valid & ~hz.flush;

  assign hz.stall     = w_stall;
  assign hz.bubble    = w_stall | hz.flush;
  assign hz.forward_a = (w_stall | w_load_a) ? '0 : w_fwd_a;
  assign hz.forward_b = (w_stall | w_load_b) ? '0 : w_fwd_b;

  // Only entry 1's load flag matters; the oldest entry's flag has no reader.
  assign w_unused_load = &{1'b0, r_load};

`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign hz.stall_count = r_stall_count;
`else
  assign hz.stall_count = '0;
`endif
endmodule
